// File: rtl/axi_alu_pkg.sv
// Shared types and AXI constants for the ALU command master.
package axi_alu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5,
    DONE = 3'd6
  } cmd_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BURST_BEATS = 4;
  localparam int         RESULT_BEAT = 3;

endpackage

// File: rtl/axi_alu_cmd_master_if.sv
// Command/result port plus AXI AW/W/B/AR/R channels between the master and its slave.
interface axi_alu_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid, cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_op1, cmd_op2, cmd_opcode;
  logic                  res_valid, res_ready, res_err;
  logic [DATA_WIDTH-1:0] res_data;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [3:0]            awlen, arlen;
  logic [2:0]            awsize, arsize;
  logic [1:0]            awburst, arburst;
  logic                  awvalid, awready, arvalid, arready;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic                  wlast, wvalid, wready;
  logic [1:0]            bresp, rresp;
  logic                  bvalid, bready;
  logic                  rlast, rvalid, rready;

  modport master (
    input  cmd_valid, cmd_addr, cmd_op1, cmd_op2, cmd_opcode, res_ready,
    output cmd_ready, res_valid, res_data, res_err,
    output awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_op1, cmd_op2, cmd_opcode, res_ready,
    input  cmd_ready, res_valid, res_data, res_err,
    input  awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_wait_watchdog.sv
// Per-channel wait watchdog; only built with AXI_ALU_CMD_MASTER_TIMEOUT_EN.
`ifdef AXI_ALU_CMD_MASTER_TIMEOUT_EN
module axi_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !active || kick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th idle wait cycle.
  assign expired = active && !kick && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/axi_alu_cmd_master.sv
// Drives one 4-beat INCR write then read-back per ALU command; returns beat 3.
// Optional watchdog: define AXI_ALU_CMD_MASTER_TIMEOUT_EN.
module axi_alu_cmd_master
  import axi_alu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  rst,
  axi_alu_cmd_master_if.master bus
);
  localparam logic [1:0] LAST = 2'(RESULT_BEAT);

  typedef struct packed {
    cmd_state_t            state;
    logic [1:0]            cnt;
    logic                  err, ovr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] op1, op2, opcode, wdata, res_data;
    logic                  awvalid, wvalid, wlast, bready, arvalid, rready, res_valid;
  } regs_t;

  regs_t r, nx;
  logic  expired;

  function automatic logic [DATA_WIDTH-1:0] beat(input regs_t s, input logic [1:0] idx);
    case (idx)
      2'd0:    return s.op1;
      2'd1:    return s.op2;
      2'd2:    return s.opcode;
      default: return '0;
    endcase
  endfunction

`ifdef AXI_ALU_CMD_MASTER_TIMEOUT_EN
  logic hs, active;
  assign hs = (r.awvalid & bus.awready) | (r.wvalid & bus.wready) | (r.bready & bus.bvalid)
            | (r.arvalid & bus.arready) | (r.rready & bus.rvalid);
  assign active = r.state inside {AW, W, B, AR, R};
  axi_wait_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk), .rst(rst), .active(active), .kick(hs), .expired(expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r <= '0;
    else     r <= nx;
  end

  always_comb begin
    nx = r;
    unique case (r.state)
      IDLE: if (bus.cmd_valid) begin
        nx.state    = AW;
        nx.addr     = bus.cmd_addr;
        nx.op1      = bus.cmd_op1;
        nx.op2      = bus.cmd_op2;
        nx.opcode   = bus.cmd_opcode;
        nx.err      = 1'b0;
        nx.res_data = '0;
        nx.cnt      = '0;
        nx.awvalid  = 1'b1;
      end
      AW: if (bus.awready) begin
        nx.awvalid = 1'b0;
        nx.wvalid  = 1'b1;
        nx.wdata   = r.op1;
        nx.wlast   = 1'b0;
        nx.cnt     = '0;
        nx.state   = W;
      end
      W: if (bus.wready) begin
        if (r.cnt == LAST) begin
          nx.wvalid = 1'b0;
          nx.wlast  = 1'b0;
          nx.bready = 1'b1;
          nx.state  = B;
        end else begin
          nx.cnt   = r.cnt + 2'd1;
          nx.wdata = beat(r, r.cnt + 2'd1);
          nx.wlast = (r.cnt + 2'd1) == LAST;
        end
      end
      B: if (bus.bvalid) begin
        if (bus.bresp != RESP_OKAY) nx.err = 1'b1;
        nx.bready  = 1'b0;
        nx.arvalid = 1'b1;
        nx.state   = AR;
      end
      AR: if (bus.arready) begin
        nx.arvalid = 1'b0;
        nx.cnt     = '0;
        nx.ovr     = 1'b0;
        nx.rready  = 1'b1;
        nx.state   = R;
      end
      R: if (bus.rvalid) begin
        if (bus.rresp != RESP_OKAY) nx.err = 1'b1;
        if (r.cnt == LAST && !r.ovr) nx.res_data = bus.rdata;
        // Overlong bursts park the counter at 3 and drain until rlast.
        if (bus.rlast) begin
          if (r.cnt != LAST) nx.err = 1'b1;
          nx.rready    = 1'b0;
          nx.res_valid = 1'b1;
          nx.state     = DONE;
        end else if (r.cnt == LAST) begin
          nx.err = 1'b1;
          nx.ovr = 1'b1;
        end else begin
          nx.cnt = r.cnt + 2'd1;
        end
      end
      DONE: if (bus.res_ready) begin
        nx.res_valid = 1'b0;
        nx.state     = IDLE;
      end
      default: nx = '0;
    endcase
    if (expired) begin
      nx.awvalid   = 1'b0;
      nx.wvalid    = 1'b0;
      nx.wlast     = 1'b0;
      nx.bready    = 1'b0;
      nx.arvalid   = 1'b0;
      nx.rready    = 1'b0;
      nx.err       = 1'b1;
      nx.res_data  = '0;
      nx.res_valid = 1'b1;
      nx.state     = DONE;
    end
  end

  assign bus.cmd_ready = (r.state == IDLE);
  assign bus.res_valid = r.res_valid;
  assign bus.res_data  = r.res_data;
  assign bus.res_err   = r.err;
  assign bus.awaddr    = r.addr;
  assign bus.awlen     = 4'(BURST_BEATS - 1);
  assign bus.awsize    = 3'd0;
  assign bus.awburst   = BURST_INCR;
  assign bus.awvalid   = r.awvalid;
  assign bus.wdata     = r.wdata;
  assign bus.wlast     = r.wlast;
  assign bus.wvalid    = r.wvalid;
  assign bus.bready    = r.bready;
  assign bus.araddr    = r.addr;
  assign bus.arlen     = 4'(BURST_BEATS - 1);
  assign bus.arsize    = 3'd0;
  assign bus.arburst   = BURST_INCR;
  assign bus.arvalid   = r.arvalid;
  assign bus.rready    = r.rready;
endmodule

// File: tb/tb_axi_alu_cmd_master.sv
// Scoreboard bench for axi_alu_cmd_master with a configurable AXI slave BFM.
module tb_axi_alu_cmd_master;
  localparam int PERIOD = 10;
`ifdef AXI_ALU_CMD_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  op1, op2, opcode;
    int          aw_stall;
    bit          aw_block;
    int          w_stall_beat, w_stall_cyc;
    logic [1:0]  bresp;
    bit          r_gap;
    int          rlast_beat, rr_hold, reps;
    logic [7:0]  exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
    time        t;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  always #(PERIOD/2) clk = ~clk;

  axi_alu_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();
  axi_alu_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int   checks = 0, errors = 0;
  exp_t q[$];
  vec_t cur;
  int   rr_hold = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] o1, o2, opc,
                              input int aws, input bit awb, input int wsb, wsc,
                              input logic [1:0] br, input bit gap, input int rlb, rrh, reps,
                              input logic [7:0] ed, input logic ee, input int lat);
    vec_t v;
    v.addr = a; v.op1 = o1; v.op2 = o2; v.opcode = opc;
    v.aw_stall = aws; v.aw_block = awb; v.w_stall_beat = wsb; v.w_stall_cyc = wsc;
    v.bresp = br; v.r_gap = gap; v.rlast_beat = rlb; v.rr_hold = rrh; v.reps = reps;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat;
    return v;
  endfunction

  function automatic logic [7:0] exp_beat(input int i);
    case (i)
      0:       return cur.op1;
      1:       return cur.op2;
      2:       return cur.opcode;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] alu(input logic [7:0] a, b, op);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [63:0] outs();
    return {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.arvalid, bus.rready,
            bus.res_valid, bus.res_err, bus.res_data, bus.awaddr};
  endfunction

  // Slave BFM: samples pre-edge handshakes, then drives its outputs 1 time unit later.
  logic [7:0] wbuf[4];
  int  aw_cnt = 0, w_idx = 0, w_stall = 0, r_idx = 0;
  bit  b_pend = 0, r_act = 0, r_tog = 0;

  function automatic logic [7:0] rbeat(input int i);
    if (i < 3)       return wbuf[i];
    else if (i == 3) return alu(wbuf[0], wbuf[1], wbuf[2]);
    else             return 8'hEE;
  endfunction

  initial begin
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.arready = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        aw_cnt = 0; w_idx = 0; w_stall = 0; b_pend = 0; r_act = 0; r_idx = 0;
      end else begin
        if (bus.awvalid) begin
          chk("aw_fields", {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
              {cur.addr, 4'd3, 3'd0, 2'b01});
          if (bus.awready) begin aw_cnt = 0; w_idx = 0; w_stall = 0; end
          else aw_cnt++;
        end
        if (bus.wvalid) begin
          chk("w_beat", {bus.wdata, bus.wlast}, {exp_beat(w_idx), 1'(w_idx == 3)});
          if (bus.wready) begin
            if (w_idx < 4) wbuf[w_idx] = bus.wdata;
            w_idx++;
            if (bus.wlast) b_pend = 1;
          end else if (w_idx == cur.w_stall_beat) w_stall++;
        end
        if (bus.bvalid && bus.bready) b_pend = 0;
        if (bus.arvalid) begin
          chk("ar_fields", {bus.araddr, bus.arlen, bus.arsize, bus.arburst},
              {cur.addr, 4'd3, 3'd0, 2'b01});
          if (bus.arready) begin r_act = 1; r_idx = 0; end
        end
        if (bus.rvalid && bus.rready) begin
          if (bus.rlast) r_act = 0;
          r_idx++;
        end
        r_tog = !r_tog;
      end
      #1;
      bus.awready = !cur.aw_block && (aw_cnt >= cur.aw_stall);
      bus.wready  = (w_idx != cur.w_stall_beat) || (w_stall >= cur.w_stall_cyc);
      bus.bvalid  = b_pend;
      bus.bresp   = cur.bresp;
      bus.arready = 1'b1;
      bus.rvalid  = r_act && (!cur.r_gap || r_tog);
      bus.rdata   = rbeat(r_idx);
      bus.rlast   = (r_idx == cur.rlast_beat);
      bus.rresp   = 2'b00;
    end
  end

  // Result-side consumer: holds res_ready low for rr_hold cycles of each result.
  initial begin
    int rr_left = 0;
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.res_valid) begin
        if (rr_left > 0) begin bus.res_ready = 1'b0; rr_left--; end
        else bus.res_ready = 1'b1;
      end else begin
        bus.res_ready = (rr_hold == 0);
        rr_left = rr_hold;
      end
    end
  end

  // Monitor: compares each presented result against the scoreboard head.
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.res_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got data %0h err %0b with nothing expected",
                   bus.res_data, bus.res_err);
        end else begin
          if (!seen) begin
            seen = 1;
            if (q[0].lat != 0)
              chk("latency", 64'(($time - q[0].t + PERIOD/2) / PERIOD), 64'(q[0].lat));
          end
          chk("res_data", bus.res_data, q[0].d);
          chk("res_err", bus.res_err, q[0].e);
          chk("quiet_in_done", {bus.cmd_ready, bus.awvalid, bus.wvalid, bus.bready,
                                bus.arvalid, bus.rready}, 6'b0);
          if (bus.res_ready) begin void'(q.pop_front()); seen = 0; end
        end
      end
    end
  end

  task automatic send(input vec_t v);
    bit ok = 0;
    time t = 0;
    bus.cmd_addr = v.addr; bus.cmd_op1 = v.op1; bus.cmd_op2 = v.op2;
    bus.cmd_opcode = v.opcode; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (bus.cmd_ready) begin ok = 1; t = $time; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready never seen for addr %0h", v.addr);
    end else begin
      chk("accept_after_consume", 64'(q.size()), 64'd0);
      q.push_back('{d: v.exp_data, e: v.exp_err, lat: v.exp_lat, t: t});
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    cur = v;
    rr_hold = v.rr_hold;
    for (int k = 0; k < v.reps; k++) send(v);
    bus.cmd_valid = 1'b0;
    drain();
    @(posedge clk); #1;
  endtask

  initial begin
    #(PERIOD * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    bit   ok;
    bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_op1 = 0; bus.cmd_op2 = 0; bus.cmd_opcode = 0;
    //           addr   op1    op2    opc  aws awb wsb wsc bresp gap rlb rrh reps data  err lat
    vecs[0] = mk(32'h10, 8'h05, 8'h03, 8'h00, 0, 0, 9, 0, 2'b00, 0, 3, 0,  1, 8'h08, 0, 12);
    vecs[1] = mk(32'h10, 8'h05, 8'h03, 8'h00, 3, 0, 1, 2, 2'b00, 1, 3, 0,  1, 8'h08, 0, 0);
    vecs[2] = mk(32'h20, 8'h0A, 8'h04, 8'h01, 0, 0, 9, 0, 2'b10, 0, 3, 0,  1, 8'h06, 1, 12);
    vecs[3] = mk(32'h30, 8'h11, 8'h22, 8'h02, 0, 0, 9, 0, 2'b00, 0, 2, 0,  1, 8'h00, 1, 11);
    vecs[4] = mk(32'h40, 8'hF0, 8'h20, 8'h00, 0, 0, 9, 0, 2'b00, 0, 3, 10, 2, 8'h10, 0, 12);
    vecs[5] = mk(32'h50, 8'hA5, 8'h0F, 8'h02, 0, 0, 9, 0, 2'b00, 0, 3, 0,  1, 8'hAA, 0, 12);
    cur = vecs[0];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outputs", outs(), 64'd0);
    chk("reset_cmd_ready", bus.cmd_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset pulse while the write burst is in flight.
    v = mk(32'h60, 8'h7F, 8'h01, 8'h00, 0, 0, 9, 0, 2'b00, 0, 3, 0, 1, 8'h80, 0, 12);
    cur = v; rr_hold = 0;
    send(v);
    bus.cmd_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (bus.wvalid) begin ok = 1; break; end
    end
    chk("reached_w_state", ok, 1'b1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    chk("midburst_reset_outputs", outs(), 64'd0);
    chk("midburst_reset_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); #1;
    run_vec(v);

`ifdef AXI_ALU_CMD_MASTER_TIMEOUT_EN
    run_vec(mk(32'h70, 8'h01, 8'h02, 8'h00, 0, 1, 9, 0, 2'b00, 0, 3, 0, 1, 8'h00, 1, 9));
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
